// File: rtl/sonido_i2c_master.sv
// ----------------------------------------------------------------------------
// sonido_i2c_master
// Write-only I2C master that sends one note code to an audio codec register.
// Each transaction is START, {DEV_ADDR,W}, REG_ADDR, note byte, STOP. Every
// state step is one quarter of an SCL period (CLK_DIV clk cycles).
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   asynchronous active-high reset
//   nota     in   note code to send (zero-extended to 8 bits on the wire)
//   start    in   one-cycle send request, honoured only in idle
//   sda_i    in   sampled SDA line (slave ACK)
//   scl      out  I2C clock, push-pull
//   sda_oe   out  1 pulls SDA low, 0 releases it
//   busy     out  transaction in progress
//   done     out  one-cycle pulse when a transaction ends
//   ack_err  out  a NACK was seen in the last transaction
// ----------------------------------------------------------------------------
module sonido_i2c_master #(
    parameter int unsigned CLK_DIV  = 125,
    parameter logic [6:0]  DEV_ADDR = 7'h1A,
    parameter logic [7:0]  REG_ADDR = 8'h00,
    parameter int unsigned NOTE_W   = 3,
    parameter int unsigned AUTO     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NOTE_W-1:0] nota,
    input  logic              start,
    input  logic              sda_i,
    output logic              scl,
    output logic              sda_oe,
    output logic              busy,
    output logic              done,
    output logic              ack_err
);

    localparam int unsigned    QW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [QW-1:0]  QMAX = QW'(CLK_DIV - 1);
    localparam logic [QW-1:0]  QONE = QW'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_BIT   = 3'd2;
    localparam logic [2:0] S_ACK   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]        r_state;
    logic [QW-1:0]     r_qcnt;
    logic [1:0]        r_qtr;       // quarter index inside the current state
    logic [2:0]        r_bit;
    logic [1:0]        r_byte;
    logic [7:0]        r_shift;
    logic [NOTE_W-1:0] r_note;
    logic [NOTE_W-1:0] r_last_sent;
    logic              r_pending;
    logic              r_nack;
    logic              r_ack_err;

    logic              w_qtick;
    logic              w_active;
    logic              w_launch;
    logic [7:0]        w_note8;

    assign w_qtick  = (r_qcnt == QMAX);
    assign w_active = (r_state == S_START) || (r_state == S_BIT) ||
                      (r_state == S_ACK)   || (r_state == S_STOP);

    // In auto mode a changed note, or a change seen while busy, counts as start.
    assign w_launch = start ||
                      ((AUTO == 1) && (r_pending || (nota != r_last_sent)));

    always_comb begin
        w_note8             = '0;
        w_note8[NOTE_W-1:0] = r_note;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_qcnt      <= '0;
            r_qtr       <= 2'd0;
            r_bit       <= 3'd0;
            r_byte      <= 2'd0;
            r_shift     <= 8'h00;
            r_note      <= '0;
            r_last_sent <= '0;
            r_pending   <= 1'b0;
            r_nack      <= 1'b0;
            r_ack_err   <= 1'b0;
        end else begin
            if (w_active) begin
                r_qcnt <= w_qtick ? '0 : r_qcnt + QONE;
            end else begin
                r_qcnt <= '0;
            end

            if ((AUTO == 1) && (r_state != S_IDLE) && (nota != r_note)) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_state     <= S_START;
                        r_note      <= nota;
                        r_last_sent <= nota;
                        r_pending   <= 1'b0;
                        r_ack_err   <= 1'b0;
                        r_qtr       <= 2'd0;
                        r_qcnt      <= '0;
                    end
                end
                S_START: begin
                    if (w_qtick) begin
                        if (r_qtr == 2'd1) begin
                            r_state <= S_BIT;
                            r_qtr   <= 2'd0;
                            r_bit   <= 3'd0;
                            r_byte  <= 2'd0;
                            r_shift <= {DEV_ADDR, 1'b0};
                        end else begin
                            r_qtr <= r_qtr + 2'd1;
                        end
                    end
                end
                S_BIT: begin
                    if (w_qtick) begin
                        r_qtr <= r_qtr + 2'd1;  // wraps 3 -> 0
                        if (r_qtr == 2'd3) begin
                            r_shift <= {r_shift[6:0], 1'b0};
                            if (r_bit == 3'd7) begin
                                r_state <= S_ACK;
                                r_bit   <= 3'd0;
                            end else begin
                                r_bit <= r_bit + 3'd1;
                            end
                        end
                    end
                end
                S_ACK: begin
                    if (w_qtick) begin
                        r_qtr <= r_qtr + 2'd1;
                        // Sample on the last cycle of q2, while SCL is high.
                        if (r_qtr == 2'd2) begin
                            r_nack <= sda_i;
                        end
                        if (r_qtr == 2'd3) begin
                            if (r_nack) begin
                                r_ack_err <= 1'b1;
                                r_state   <= S_STOP;
                            end else if (r_byte == 2'd2) begin
                                r_state <= S_STOP;
                            end else begin
                                r_state <= S_BIT;
                                r_byte  <= r_byte + 2'd1;
                                r_shift <= (r_byte == 2'd0) ? REG_ADDR : w_note8;
                            end
                        end
                    end
                end
                S_STOP: begin
                    if (w_qtick) begin
                        if (r_qtr == 2'd2) begin
                            r_state <= S_DONE;
                            r_qtr   <= 2'd0;
                        end else begin
                            r_qtr <= r_qtr + 2'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only, so reset reaches the pins at once.
    always_comb begin
        scl    = 1'b1;
        sda_oe = 1'b0;
        case (r_state)
            S_START: begin
                sda_oe = (r_qtr == 2'd1);
            end
            S_BIT: begin
                scl    = r_qtr[1];
                sda_oe = ~r_shift[7];
            end
            S_ACK: begin
                scl = r_qtr[1];
            end
            S_STOP: begin
                scl    = (r_qtr != 2'd0);
                sda_oe = (r_qtr != 2'd2);
            end
            default: begin
                scl    = 1'b1;
                sda_oe = 1'b0;
            end
        endcase
    end

    assign busy    = w_active;
    assign done    = (r_state == S_DONE);
    assign ack_err = r_ack_err;

endmodule

// File: tb/tb_sonido_i2c_master.sv
// ----------------------------------------------------------------------------
// tb_sonido_i2c_master
// Directed bench for sonido_i2c_master with CLK_DIV=4. Three instances:
//   u_man  : AUTO=0, NOTE_W=3
//   u_auto : AUTO=1, NOTE_W=3
//   u_w8   : AUTO=0, NOTE_W=8
// A bus monitor decodes bytes and STOP conditions from the selected instance;
// a slave model answers NACK on a chosen byte, ACK otherwise.
// ----------------------------------------------------------------------------
module tb_sonido_i2c_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] nota0 = 3'd0;
    logic [2:0] nota1 = 3'd0;
    logic [7:0] nota2 = 8'd0;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic       start2 = 1'b0;
    logic       sda_drv;
    logic [2:0] scl_v, oe_v, busy_v, done_v, err_v;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    sonido_i2c_master #(.CLK_DIV(4), .NOTE_W(3), .AUTO(0)) u_man (
        .clk(clk), .rst(rst), .nota(nota0), .start(start0), .sda_i(sda_drv),
        .scl(scl_v[0]), .sda_oe(oe_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .ack_err(err_v[0])
    );
    sonido_i2c_master #(.CLK_DIV(4), .NOTE_W(3), .AUTO(1)) u_auto (
        .clk(clk), .rst(rst), .nota(nota1), .start(start1), .sda_i(sda_drv),
        .scl(scl_v[1]), .sda_oe(oe_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .ack_err(err_v[1])
    );
    sonido_i2c_master #(.CLK_DIV(4), .NOTE_W(8), .AUTO(0)) u_w8 (
        .clk(clk), .rst(rst), .nota(nota2), .start(start2), .sda_i(sda_drv),
        .scl(scl_v[2]), .sda_oe(oe_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .ack_err(err_v[2])
    );

    // Bus monitor on the selected instance, sampled on the falling clock edge.
    int         mon_sel = 0;
    logic       m_scl, m_sda;
    logic       p_scl = 1'b1;
    logic       p_sda = 1'b1;
    int         bitc = 0;
    logic [7:0] shr = 8'h00;
    logic [7:0] mon_b [64];
    int         widx = 0;
    int         nstop = 0;

    assign m_scl = scl_v[mon_sel];
    assign m_sda = ~oe_v[mon_sel];

    always @(negedge clk) begin
        if (m_scl && p_scl && p_sda && !m_sda) begin
            bitc <= 0;
        end else if (m_scl && p_scl && !p_sda && m_sda) begin
            nstop <= nstop + 1;
        end else if (m_scl && !p_scl) begin
            if (bitc == 8) begin
                mon_b[widx % 64] <= shr;
                widx <= widx + 1;
                bitc <= 0;
            end else begin
                shr  <= {shr[6:0], m_sda};
                bitc <= bitc + 1;
            end
        end
        p_scl <= m_scl;
        p_sda <= m_sda;
    end

    // Slave: NACK the ACK slot of byte nack_k (1-based), ACK (hold low) otherwise.
    int base = 0;
    int nack_k = 0;
    assign sda_drv = (nack_k != 0) && ((widx - base) == nack_k);

    typedef struct {
        int         sel;
        logic [7:0] nota;
        int         nack;
        int         exp_cyc;
        int         exp_err;
        int         exp_nb;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic launch(input int sel, input logic [7:0] n);
        @(negedge clk);
        base = widx;
        case (sel)
            0: begin nota0 = n[2:0]; start0 = 1'b1; end
            1: begin nota1 = n[2:0]; start1 = 1'b1; end
            default: begin nota2 = n; start2 = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    // Cycles from the accepting edge to the first done; -1 if it never comes.
    task automatic wait_done(input int sel, output int cyc);
        cyc = -1;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge clk);
            #1;
            if (done_v[sel]) begin
                cyc = c;
                break;
            end
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int cyc, s0, d1, d2, rise, nd, first;

        vecs[0] = '{0, 8'h05, 0, 452, 0, 3, 8'h05};
        vecs[1] = '{0, 8'h03, 1, 164, 1, 1, 8'h00};
        vecs[2] = '{0, 8'h07, 2, 308, 1, 2, 8'h00};
        vecs[3] = '{0, 8'h00, 3, 452, 1, 3, 8'h00};
        vecs[4] = '{0, 8'h06, 0, 452, 0, 3, 8'h06};
        vecs[5] = '{2, 8'hFF, 0, 452, 0, 3, 8'hFF};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_scl", int'(scl_v[0]), 1);
        check("rst_sda_oe", int'(oe_v[0]), 0);
        check("rst_busy", int'(busy_v[0]), 0);
        check("rst_done", int'(done_v[0]), 0);
        check("rst_ack_err", int'(err_v[0]), 0);
        @(negedge clk);
        rst = 1'b0;

        // Table of complete transactions
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mon_sel = vecs[i].sel;
            nack_k  = vecs[i].nack;
            s0      = nstop;
            launch(vecs[i].sel, vecs[i].nota);
            wait_done(vecs[i].sel, cyc);
            check($sformatf("v%0d_done_cycle", i), cyc, vecs[i].exp_cyc);
            check($sformatf("v%0d_busy_at_done", i), int'(busy_v[vecs[i].sel]), 0);
            repeat (5) @(posedge clk);
            #1;
            check($sformatf("v%0d_ack_err", i), int'(err_v[vecs[i].sel]), vecs[i].exp_err);
            check($sformatf("v%0d_nbytes", i), widx - base, vecs[i].exp_nb);
            check($sformatf("v%0d_stops", i), nstop - s0, 1);
            check($sformatf("v%0d_addr_byte", i), int'(mon_b[base % 64]), 8'h34);
            if (vecs[i].exp_nb >= 2)
                check($sformatf("v%0d_reg_byte", i), int'(mon_b[(base + 1) % 64]), 8'h00);
            if (vecs[i].exp_nb == 3)
                check($sformatf("v%0d_data_byte", i), int'(mon_b[(base + 2) % 64]),
                      int'(vecs[i].exp_data));
        end
        nack_k = 0;

        // Start pulsed while busy is ignored, AUTO=0
        mon_sel = 0;
        launch(0, 8'h01);
        nd = 0;
        first = -1;
        for (int c = 1; c <= 1000; c++) begin
            @(posedge clk);
            #1;
            if (c == 100) start0 = 1'b1;
            if (c == 101) start0 = 1'b0;
            if (done_v[0]) begin
                nd++;
                if (first < 0) first = c;
            end
        end
        check("busy_start_first_done", first, 452);
        check("busy_start_done_count", nd, 1);

        // AUTO=1: 0->3 launches, 3->6 while busy is queued
        @(negedge clk);
        mon_sel = 1;
        launch(1, 8'h03);
        nd = 0; d1 = -1; d2 = -1; rise = -1;
        for (int c = 1; c <= 1100; c++) begin
            @(posedge clk);
            #1;
            if (c == 50) nota1 = 3'd6;
            if (done_v[1]) begin
                nd++;
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
            if (d1 > 0 && rise < 0 && busy_v[1]) rise = c;
        end
        check("auto_first_done", d1, 452);
        check("auto_second_busy", rise, 454);  // one IDLE cycle after the done cycle
        check("auto_second_done", d2, 906);
        check("auto_done_count", nd, 2);
        check("auto_nbytes", widx - base, 6);
        check("auto_data1", int'(mon_b[(base + 2) % 64]), 8'h03);
        check("auto_data2", int'(mon_b[(base + 5) % 64]), 8'h06);

        // AUTO=1: start and note change together give one transaction
        launch(1, 8'h02);
        nd = 0;
        first = -1;
        for (int c = 1; c <= 700; c++) begin
            @(posedge clk);
            #1;
            if (done_v[1]) begin
                nd++;
                if (first < 0) first = c;
            end
        end
        check("auto_same_first_done", first, 452);
        check("auto_same_done_count", nd, 1);
        check("auto_same_nbytes", widx - base, 3);
        check("auto_same_data", int'(mon_b[(base + 2) % 64]), 8'h02);

        // Reset during the REG_ADDR byte, then start on the first edge after it
        @(negedge clk);
        mon_sel = 0;
        launch(0, 8'h05);
        repeat (199) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_scl", int'(scl_v[0]), 1);
        check("abort_sda_oe", int'(oe_v[0]), 0);
        check("abort_busy", int'(busy_v[0]), 0);
        check("abort_done", int'(done_v[0]), 0);
        check("abort_ack_err", int'(err_v[0]), 0);
        @(negedge clk);
        rst   = 1'b0;
        nota0 = 3'd4;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        wait_done(0, cyc);
        check("post_rst_done_cycle", cyc, 452);
        check("post_rst_ack_err", int'(err_v[0]), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
